// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder with branch-target add, two-stage valid/ready pipeline.
// Latency 2 cycles; out_ready stalls stage 2 and then stage 1, in_ready drops only when both are full.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_misaligned,
  output logic [15:0]     illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [2:0]      dec_fmt;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;

  logic            s1_vld_q, s1_vld_d;
  logic [2:0]      s1_fmt_q, s1_fmt_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;

  logic            s2_vld_q, s2_vld_d;
  logic [2:0]      s2_fmt_q, s2_fmt_d;
  logic [XLEN-1:0] s2_imm_q, s2_imm_d;
  logic [XLEN-1:0] s2_tgt_q, s2_tgt_d;
  logic            s2_mis_q, s2_mis_d;

  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] s1_tgt;
  logic            s1_adv, s2_adv, in_fire, s2_load;

  always_comb begin
    dec_fmt = FMT_ILL;
    case (in_instr[6:0])
      7'b0110011:                                 dec_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
      7'b0100011:                                 dec_fmt = FMT_S;
      7'b1100011:                                 dec_fmt = FMT_B;
      7'b0110111, 7'b0010111:                     dec_fmt = FMT_U;
      7'b1101111:                                 dec_fmt = FMT_J;
      // RV64-only OP-IMM-32 / OP-32
      7'b0011011:                                 dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0111011:                                 dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                                    dec_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    dec_imm32 = '0;
    case (dec_fmt)
      FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: dec_imm32 = {in_instr[31:12], 12'b0};
      FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
    dec_imm = XLEN'($signed(dec_imm32));
  end

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign s2_load  = s1_vld_q && s2_adv;
  assign s1_tgt   = s1_pc_q + s1_imm_q;

  always_comb begin
    s1_vld_d = s1_adv ? in_valid : s1_vld_q;
    s1_fmt_d = in_fire ? dec_fmt : s1_fmt_q;
    s1_imm_d = in_fire ? dec_imm : s1_imm_q;
    s1_pc_d  = in_fire ? in_pc   : s1_pc_q;

    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    s2_fmt_d = s2_load ? s1_fmt_q : s2_fmt_q;
    s2_imm_d = s2_load ? s1_imm_q : s2_imm_q;
    s2_tgt_d = s2_load ? s1_tgt   : s2_tgt_q;
    s2_mis_d = s2_load ? (s1_tgt[1] && (s1_fmt_q == FMT_B || s1_fmt_q == FMT_J)) : s2_mis_q;

    cnt_d = cnt_q;
    if (in_fire && dec_fmt == FMT_ILL && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_fmt_q <= '0;
      s1_imm_q <= '0;
      s1_pc_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_fmt_q <= '0;
      s2_imm_q <= '0;
      s2_tgt_q <= '0;
      s2_mis_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_fmt_q <= s1_fmt_d;
      s1_imm_q <= s1_imm_d;
      s1_pc_q  <= s1_pc_d;
      s2_vld_q <= s2_vld_d;
      s2_fmt_q <= s2_fmt_d;
      s2_imm_q <= s2_imm_d;
      s2_tgt_q <= s2_tgt_d;
      s2_mis_q <= s2_mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid      = s2_vld_q;
  assign out_imm        = s2_imm_q;
  assign out_target     = s2_tgt_q;
  assign out_fmt        = s2_fmt_q;
  assign out_misaligned = s2_mis_q;
  assign illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Random and directed bench driving XLEN=32 and XLEN=64 instances in lockstep against a queue model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] in_instr, pc32;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, mis32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;
  logic        in_ready64, out_valid64, mis64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32), .out_fmt(fmt32), .out_misaligned(mis32),
    .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64), .out_fmt(fmt64), .out_misaligned(mis64),
    .illegal_cnt(cnt64));

  typedef struct {
    int          fmt32, fmt64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    bit          mis32, mis64;
    int          acc;
  } beat_t;

  beat_t       q[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, mcnt32 = 0, mcnt64 = 0;
  bit          rst_prev = 1'b1, hold = 1'b0;
  logic [31:0] h_imm32, h_tgt32;
  logic [63:0] h_imm64, h_tgt64;
  logic [2:0]  h_fmt32, h_fmt64;
  logic        h_mis32, h_mis64;

  localparam int OPS [15] = '{'h33, 'h13, 'h03, 'h67, 'h73, 'h23, 'h63, 'h37,
                              'h17, 'h6F, 'h1B, 'h3B, 'h7F, 'h00, 'h0B};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: format from the opcode table, immediate as a signed integer value.
  function automatic void ref_dec(input logic [31:0] i, input bit x64,
                                  output int fmt, output longint imm);
    longint u, v;
    int     w;
    u = 0; u[31:0] = i;
    case (u % 128)
      'h33:                   fmt = 0;
      'h13, 'h03, 'h67, 'h73: fmt = 1;
      'h23:                   fmt = 2;
      'h63:                   fmt = 3;
      'h37, 'h17:             fmt = 4;
      'h6F:                   fmt = 5;
      'h1B:                   fmt = x64 ? 1 : 7;
      'h3B:                   fmt = x64 ? 0 : 7;
      default:                fmt = 7;
    endcase
    v = 0; w = 1;
    case (fmt)
      1: begin v = u / 2**20; w = 12; end
      2: begin v = (u / 2**25) * 32 + (u / 2**7) % 32; w = 12; end
      3: begin v = ((u / 2**31) % 2) * 2**12 + ((u / 2**7) % 2) * 2**11
                 + ((u / 2**25) % 64) * 2**5 + ((u / 2**8) % 16) * 2; w = 13; end
      4: begin v = (u / 2**12) * 2**12; w = 32; end
      5: begin v = ((u / 2**31) % 2) * 2**20 + ((u / 2**12) % 256) * 2**12
                 + ((u / 2**20) % 2) * 2**11 + ((u / 2**21) % 1024) * 2; w = 21; end
      default: begin v = 0; w = 1; end
    endcase
    imm = (v >= 2**(w-1) && w > 1) ? v - 2**w : v;
  endfunction

  task automatic sample();
    bit     exp_ov, exp_ir;
    beat_t  b;
    int     f;
    longint im;
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    exp_ir = (q.size() < 2) || out_ready;
    check_eq("out_valid32", out_valid32, exp_ov);
    check_eq("out_valid64", out_valid64, exp_ov);
    check_eq("in_ready32", in_ready32, exp_ir);
    check_eq("in_ready64", in_ready64, exp_ir);
    check_eq("illegal_cnt32", cnt32, mcnt32);
    check_eq("illegal_cnt64", cnt64, mcnt64);
    if (rst_prev) begin
      check_eq("rst_out32", {imm32, tgt32}, 64'h0);
      check_eq("rst_fmt_mis32", {fmt32, mis32}, 4'h0);
      check_eq("rst_out64", imm64 | tgt64, 64'h0);
    end
    if (hold) begin
      check_eq("hold32", {imm32, tgt32}, {h_imm32, h_tgt32});
      check_eq("hold_fm32", {fmt32, mis32}, {h_fmt32, h_mis32});
      check_eq("hold_imm64", imm64, h_imm64);
      check_eq("hold_tgt64", tgt64, h_tgt64);
      check_eq("hold_fm64", {fmt64, mis64}, {h_fmt64, h_mis64});
    end
    if (exp_ov && out_ready) begin
      b = q.pop_front();
      check_eq("imm32", imm32, b.imm32);
      check_eq("tgt32", tgt32, b.tgt32);
      check_eq("fmt32", fmt32, b.fmt32);
      check_eq("mis32", mis32, b.mis32);
      check_eq("imm64", imm64, b.imm64);
      check_eq("tgt64", tgt64, b.tgt64);
      check_eq("fmt64", fmt64, b.fmt64);
      check_eq("mis64", mis64, b.mis64);
    end
    if (reset) begin
      q.delete();
      mcnt32 = 0; mcnt64 = 0; hold = 1'b0;
    end else begin
      if (in_valid && exp_ir) begin
        ref_dec(in_instr, 1'b0, f, im);
        b.fmt32 = f; b.imm32 = im[31:0]; b.tgt32 = pc32 + im[31:0];
        b.mis32 = (f == 3 || f == 5) && b.tgt32[1];
        if (f == 7 && mcnt32 < 'hFFFF) mcnt32++;
        ref_dec(in_instr, 1'b1, f, im);
        b.fmt64 = f; b.imm64 = im; b.tgt64 = pc64 + im;
        b.mis64 = (f == 3 || f == 5) && b.tgt64[1];
        if (f == 7 && mcnt64 < 'hFFFF) mcnt64++;
        b.acc = cyc;
        q.push_back(b);
      end
      hold = exp_ov && !out_ready;
      h_imm32 = imm32; h_tgt32 = tgt32; h_fmt32 = fmt32; h_mis32 = mis32;
      h_imm64 = imm64; h_tgt64 = tgt64; h_fmt64 = fmt64; h_mis64 = mis64;
    end
    rst_prev = reset;
    cyc++;
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit ordy, input bit rst);
    @(negedge clk);
    in_valid = v; in_instr = ins; pc64 = pc; pc32 = pc[31:0];
    out_ready = ordy; reset = rst;
    #1;
    sample();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; pc32 = '0; pc64 = '0;
    repeat (2) @(negedge clk);
    idle(1);

    step(1'b1, 32'hFE000EE3, 64'h100, 1'b1, 1'b0);
    idle(2);
    check_eq("b_imm", imm32, 32'hFFFFFFFC);
    check_eq("b_tgt", tgt32, 32'h000000FC);
    check_eq("b_fmt", fmt32, 3);
    check_eq("b_mis", mis32, 0);

    step(1'b1, 32'h0080006F, 64'h200, 1'b1, 1'b0);
    idle(2);
    check_eq("j_imm", imm32, 32'h8);
    check_eq("j_tgt", tgt32, 32'h208);
    check_eq("j_fmt", fmt32, 5);

    step(1'b1, 32'h123450B7, 64'h0, 1'b1, 1'b0);
    step(1'b1, 32'hFFF00093, 64'h0, 1'b1, 1'b0);
    idle(1);
    check_eq("u_imm", imm32, 32'h12345000);
    check_eq("u_fmt", fmt32, 4);
    idle(1);
    check_eq("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    check_eq("i_fmt64", fmt64, 1);

    step(1'b1, 32'h00000163, 64'h100, 1'b1, 1'b0);
    idle(2);
    check_eq("mis_tgt", tgt32, 32'h102);
    check_eq("mis_flag", mis32, 1);

    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    idle(2);
    check_eq("ill_fmt", fmt32, 7);
    check_eq("ill_imm", imm32, 0);
    check_eq("ill_cnt", cnt32, 1);

    // Backpressure: third back-to-back beat must be refused while outputs are stalled.
    step(1'b1, 32'h00100093, 64'h10, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 64'h20, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 64'h30, 1'b0, 1'b0);
    check_eq("bp_ready3", in_ready32, 0);
    step(1'b1, 32'h00300093, 64'h30, 1'b0, 1'b0);
    check_eq("bp_stall_imm", imm32, 32'h1);
    step(1'b1, 32'h00300093, 64'h30, 1'b1, 1'b0);
    check_eq("bp_first_out", imm32, 32'h1);
    idle(1);
    check_eq("bp_second_out", imm32, 32'h2);
    idle(1);
    check_eq("bp_third_out", imm32, 32'h3);
    idle(1);

    // Reset with two beats in flight, one more offered during the reset cycle.
    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b1);
    idle(1);
    check_eq("flush_valid", out_valid32, 0);
    check_eq("flush_cnt", cnt32, 0);
    step(1'b1, 32'h00500093, 64'h0, 1'b1, 1'b0);
    idle(1);
    check_eq("flush_lat1", out_valid32, 0);
    idle(1);
    check_eq("flush_lat2", out_valid32, 1);
    check_eq("flush_imm", imm32, 32'h5);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] hi;
      r = $urandom();
      hi = $urandom();
      step($urandom_range(0, 9) < 7, {r[31:7], OPS[$urandom_range(0, 14)][6:0]},
           {hi, $urandom()}, $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end

    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
    for (int n = 0; n < 'h10000; n++) step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    idle(1);
    check_eq("sat_cnt", cnt32, 16'hFFFF);
    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    idle(3);
    check_eq("sat_hold", cnt32, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on rising clk.
REQ-004 The block SHALL have port in_valid, input, 1 bit, input beat present.
REQ-005 The block SHALL have port in_ready, output, 1 bit, block accepts the input beat this cycle.
REQ-006 The block SHALL have port in_instr, input, 32 bits, RV instruction word.
REQ-007 The block SHALL have port in_pc, input, XLEN bits, address of in_instr.
REQ-008 The block SHALL have port out_valid, output, 1 bit, result beat present.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer accepts the result beat.
REQ-010 The block SHALL have port out_imm, output, XLEN bits, sign-extended immediate.
REQ-011 The block SHALL have port out_target, output, XLEN bits, in_pc + out_imm, modulo 2^XLEN.
REQ-012 The block SHALL have port out_fmt, output, 3 bits, format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-013 The block SHALL have port out_misaligned, output, 1 bit, out_target[1] set for fmt B or J.
REQ-014 The block SHALL have port illegal_cnt, output, 16 bits, saturating count of accepted illegal opcodes.

Function
REQ-015 Opcode decode on in_instr[6:0] SHALL be: 0110011 R; 0010011, 0000011, 1100111, 1110011 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; any other opcode illegal.
REQ-016 When XLEN=64, opcode 0011011 SHALL decode as I and 0111011 as R; when XLEN=32, both SHALL decode as illegal.
REQ-017 Immediates SHALL be: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; U {inst[31:12],12'b0}.
REQ-018 Every immediate SHALL be sign-extended from inst[31] to XLEN bits; R and illegal SHALL give imm 0.
REQ-019 Pipeline stage 1 SHALL register the decoded format, the extended immediate and pc; stage 2 SHALL register the target add and the misaligned flag.
REQ-020 Latency SHALL be exactly 2 cycles from input handshake (in_valid&in_ready) to out_valid when there is no backpressure.
REQ-021 Stage 2 SHALL advance when it is empty or out_ready=1; stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-022 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances; it is combinational from out_ready.
REQ-023 Throughput SHALL be 1 beat/cycle with out_ready held 1.
REQ-024 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-025 Beats SHALL be neither dropped, duplicated nor reordered; capacity SHALL be exactly 2 beats.
REQ-026 illegal_cnt SHALL increment by 1 on each accepted illegal beat and SHALL saturate at 0xFFFF.

Reset
REQ-027 On reset=1, both stage valid bits SHALL clear, giving out_valid=0 and in_ready=1 on the next cycle.
REQ-028 On reset=1, illegal_cnt SHALL be set to 0, and out_imm, out_target, out_fmt and out_misaligned SHALL be set to 0.
REQ-029 A reset asserted mid-stream SHALL discard all in-flight beats, and no beat accepted in the reset cycle SHALL be counted or emitted.

Verification
REQ-030 B-type SHALL decode correctly: XLEN=32, instr 0xFE000EE3, pc 0x100 -> after 2 cycles out_imm 0xFFFFFFFC, out_target 0x000000FC, fmt 3, misaligned 0.
REQ-031 J-type SHALL decode correctly: instr 0x0080006F, pc 0x200 -> out_imm 0x8, out_target 0x208, fmt 5.
REQ-032 U-type and I-type SHALL decode correctly: instr 0x123450B7 -> out_imm 0x12345000, fmt 4; with XLEN=64, instr 0xFFF00093 -> out_imm 0xFFFFFFFFFFFFFFFF, fmt 1.
REQ-033 Misaligned and illegal beats SHALL be flagged: instr 0x00000163, pc 0x100 -> target 0x102, misaligned 1; instr 0x0000007F -> fmt 7, imm 0, illegal_cnt 1; 0x10000 illegal beats -> illegal_cnt 0xFFFF.
REQ-034 Backpressure SHALL be honoured: out_ready=0 while 3 beats are offered back-to-back -> 2 accepted, in_ready=0 on the 3rd, outputs stable; out_ready=1 -> beats emerge in order, one per cycle.
REQ-035 Reset mid-stream SHALL flush the pipeline: reset pulsed with 2 beats in flight -> out_valid=0 next cycle, illegal_cnt 0, and the next accepted beat emerges after 2 cycles.
